// File: rtl/rom_arbiter_if.sv
// rtl/rom_arbiter_if.sv - fetch, debug and ROM-side signal bundle for rom_arbiter
// slave modport is the arbiter's view; master is the view of whatever drives the requests and models the ROM.
interface rom_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_stall_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;

  logic              dbg_req_i;
  logic [ADDR_W-1:0] dbg_addr_i;
  logic              dbg_gnt_o;
  logic              dbg_rvalid_o;
  logic [DATA_W-1:0] dbg_rdata_o;

  logic              rom_ce_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [DATA_W-1:0] rom_data_i;

  modport slave (
    input  if_req_i, if_addr_i, dbg_req_i, dbg_addr_i, rom_data_i,
    output if_gnt_o, if_stall_o, if_rvalid_o, if_rdata_o,
    output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, rom_ce_o, rom_addr_o
  );

  modport master (
    output if_req_i, if_addr_i, dbg_req_i, dbg_addr_i, rom_data_i,
    input  if_gnt_o, if_stall_o, if_rvalid_o, if_rdata_o,
    input  dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, rom_ce_o, rom_addr_o
  );
endinterface

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - two-port (fetch/debug) arbiter in front of a combinational ROM, read latency 1
// Fetch has fixed priority; define ROM_ARB_STARVE_GUARD_EN to force a debug win after STARVE_LIMIT refused cycles.
module rom_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  rom_arbiter_if.slave      bus,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

  owner_e            resp_owner_q, resp_owner_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              if_gnt, dbg_gnt, force_dbg;

`ifdef ROM_ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_q, starve_d;

  assign force_dbg = (starve_q == CNT_W'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (!bus.dbg_req_i || dbg_gnt) begin
      starve_d = '0;
    end else if (!force_dbg) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  // The limit only matters to the guarded build; without it debug may starve.
  localparam int unsigned unused_starve_limit = STARVE_LIMIT;

  assign force_dbg = 1'b0;
`endif

  always_comb begin
    dbg_gnt = bus.dbg_req_i & (~bus.if_req_i | force_dbg);
    if_gnt  = bus.if_req_i & ~dbg_gnt;
  end

  always_comb begin
    resp_owner_d = OWN_NONE;
    if_rdata_d   = if_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    if (if_gnt) begin
      resp_owner_d = OWN_IF;
      if_rdata_d   = bus.rom_data_i;
    end else if (dbg_gnt) begin
      resp_owner_d = OWN_DBG;
      dbg_rdata_d  = bus.rom_data_i;
    end
  end

  // Clearing the owner on reset discards any in-flight response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_owner_q <= OWN_NONE;
      if_rdata_q   <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      resp_owner_q <= resp_owner_d;
      if_rdata_q   <= if_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign bus.if_gnt_o     = if_gnt;
  assign bus.dbg_gnt_o    = dbg_gnt;
  assign bus.if_stall_o   = bus.if_req_i & ~if_gnt;
  assign bus.rom_ce_o     = if_gnt | dbg_gnt;
  assign bus.rom_addr_o   = if_gnt  ? bus.if_addr_i  :
                            dbg_gnt ? bus.dbg_addr_i : '0;
  assign bus.if_rvalid_o  = (resp_owner_q == OWN_IF);
  assign bus.dbg_rvalid_o = (resp_owner_q == OWN_DBG);
  assign bus.if_rdata_o   = if_rdata_q;
  assign bus.dbg_rdata_o  = dbg_rdata_q;
  assign busy_o           = (resp_owner_q != OWN_NONE);

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - directed self-checking bench for rom_arbiter
// Starvation scenario follows ROM_ARB_STARVE_GUARD_EN; the ROM answers 0x3401_1100 at 0x4, else 0xA5A5_0000 ^ addr.
module tb_rom_arbiter;

  logic clk;
  logic rst;
  logic busy;
  int   n_cmp;
  int   n_fail;

  rom_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  rom_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .STARVE_LIMIT(8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .busy_o(busy)
  );

  function automatic logic [31:0] rom_f(input logic [31:0] a);
    if (a == 32'h4) return 32'h3401_1100;
    return 32'hA5A5_0000 ^ a;
  endfunction

  assign bus.rom_data_i = rom_f(bus.rom_addr_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da);
    bus.if_req_i   = ir;
    bus.if_addr_i  = ia;
    bus.dbg_req_i  = dr;
    bus.dbg_addr_i = da;
  endtask

  initial begin
    logic exp_dbg;
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0);

    // Reset state
    next_cycle();
    sample();
    chk("rst_busy",       32'(busy),             32'h0);
    chk("rst_if_rvalid",  32'(bus.if_rvalid_o),  32'h0);
    chk("rst_dbg_rvalid", 32'(bus.dbg_rvalid_o), 32'h0);
    chk("rst_if_rdata",   bus.if_rdata_o,        32'h0);
    chk("rst_dbg_rdata",  bus.dbg_rdata_o,       32'h0);
    chk("rst_rom_ce",     32'(bus.rom_ce_o),     32'h0);
    chk("rst_rom_addr",   bus.rom_addr_o,        32'h0);
    next_cycle();
    rst = 1'b1;

    // Lone fetch at 0x4, first cycle after release
    drive(1'b1, 32'h4, 1'b0, 32'h0);
    sample();
    chk("lone_if_gnt",    32'(bus.if_gnt_o),    32'h1);
    chk("lone_rom_addr",  bus.rom_addr_o,       32'h4);
    chk("lone_rom_ce",    32'(bus.rom_ce_o),    32'h1);
    chk("lone_if_stall",  32'(bus.if_stall_o),  32'h0);
    chk("lone_rvalid_n",  32'(bus.if_rvalid_o), 32'h0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    sample();
    chk("lone_rvalid_n1", 32'(bus.if_rvalid_o), 32'h1);
    chk("lone_rdata_n1",  bus.if_rdata_o,       32'h3401_1100);
    chk("lone_busy_n1",   32'(busy),            32'h1);
    chk("lone_rom_ce_n1", 32'(bus.rom_ce_o),    32'h0);
    next_cycle();
    sample();
    chk("lone_rvalid_n2", 32'(bus.if_rvalid_o), 32'h0);
    chk("lone_rdata_hold",bus.if_rdata_o,       32'h3401_1100);
    chk("lone_busy_n2",   32'(busy),            32'h0);

    // Contention for one cycle: fetch 0x8 beats debug 0x40
    next_cycle();
    drive(1'b1, 32'h8, 1'b1, 32'h40);
    sample();
    chk("both_if_gnt",   32'(bus.if_gnt_o),   32'h1);
    chk("both_dbg_gnt",  32'(bus.dbg_gnt_o),  32'h0);
    chk("both_if_stall", 32'(bus.if_stall_o), 32'h0);
    chk("both_rom_addr", bus.rom_addr_o,      32'h8);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    sample();
    chk("both_if_rvalid",  32'(bus.if_rvalid_o),  32'h1);
    chk("both_if_rdata",   bus.if_rdata_o,        32'hA5A5_0008);
    chk("both_dbg_rvalid", 32'(bus.dbg_rvalid_o), 32'h0);
    next_cycle();
    sample();
    chk("both_dbg_rvalid2", 32'(bus.dbg_rvalid_o), 32'h0);
    chk("both_dbg_rdata",   bus.dbg_rdata_o,       32'h0);

    // Back-to-back fetches 0x0, 0x4, 0x8
    next_cycle();
    drive(1'b1, 32'h0, 1'b0, 32'h0);
    sample();
    chk("b2b_gnt0", 32'(bus.if_gnt_o), 32'h1);
    next_cycle();
    drive(1'b1, 32'h4, 1'b0, 32'h0);
    sample();
    chk("b2b_rvalid0", 32'(bus.if_rvalid_o), 32'h1);
    chk("b2b_rdata0",  bus.if_rdata_o,       32'hA5A5_0000);
    chk("b2b_busy0",   32'(busy),            32'h1);
    next_cycle();
    drive(1'b1, 32'h8, 1'b0, 32'h0);
    sample();
    chk("b2b_rvalid1", 32'(bus.if_rvalid_o), 32'h1);
    chk("b2b_rdata1",  bus.if_rdata_o,       32'h3401_1100);
    chk("b2b_busy1",   32'(busy),            32'h1);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    sample();
    chk("b2b_rvalid2", 32'(bus.if_rvalid_o), 32'h1);
    chk("b2b_rdata2",  bus.if_rdata_o,       32'hA5A5_0008);
    chk("b2b_busy2",   32'(busy),            32'h1);
    next_cycle();
    sample();
    chk("b2b_rvalid3", 32'(bus.if_rvalid_o), 32'h0);
    chk("b2b_busy3",   32'(busy),            32'h0);

    // Lone debug read at 0x40
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 32'h40);
    sample();
    chk("dbg_gnt",      32'(bus.dbg_gnt_o),  32'h1);
    chk("dbg_rom_addr", bus.rom_addr_o,      32'h40);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    sample();
    chk("dbg_rvalid",     32'(bus.dbg_rvalid_o), 32'h1);
    chk("dbg_rdata",      bus.dbg_rdata_o,       32'hA5A5_0040);
    chk("dbg_if_rvalid",  32'(bus.if_rvalid_o),  32'h0);
    chk("dbg_if_rdata",   bus.if_rdata_o,        32'hA5A5_0008);

    // Both ports requesting continuously
    next_cycle();
    drive(1'b1, 32'h10, 1'b1, 32'h20);
`ifdef ROM_ARB_STARVE_GUARD_EN
    for (int k = 0; k < 27; k++) begin
      exp_dbg = ((k % 9) == 8);
      sample();
      chk($sformatf("starve_dbg_gnt_%0d", k),  32'(bus.dbg_gnt_o),  32'(exp_dbg));
      chk($sformatf("starve_if_gnt_%0d", k),   32'(bus.if_gnt_o),   32'(!exp_dbg));
      chk($sformatf("starve_if_stall_%0d", k), 32'(bus.if_stall_o), 32'(exp_dbg));
      next_cycle();
    end
`else
    exp_dbg = 1'b0;
    for (int k = 0; k < 50; k++) begin
      sample();
      chk($sformatf("nostarve_dbg_gnt_%0d", k), 32'(bus.dbg_gnt_o), 32'(exp_dbg));
      chk($sformatf("nostarve_if_gnt_%0d", k),  32'(bus.if_gnt_o),  32'h1);
      next_cycle();
    end
`endif
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    next_cycle();

    // Reset right after a debug grant discards the pending response
    drive(1'b0, 32'h0, 1'b1, 32'h44);
    sample();
    chk("rstp_dbg_gnt", 32'(bus.dbg_gnt_o), 32'h1);
    next_cycle();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    sample();
    chk("rstp_dbg_rvalid", 32'(bus.dbg_rvalid_o), 32'h0);
    chk("rstp_dbg_rdata",  bus.dbg_rdata_o,       32'h0);
    chk("rstp_busy",       32'(busy),             32'h0);
    next_cycle();
    rst = 1'b1;
    sample();
    chk("rstp_dbg_rvalid2", 32'(bus.dbg_rvalid_o), 32'h0);
    chk("rstp_busy2",       32'(busy),             32'h0);
    next_cycle();
    drive(1'b1, 32'h4, 1'b0, 32'h0);
    sample();
    chk("post_if_gnt", 32'(bus.if_gnt_o), 32'h1);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    sample();
    chk("post_if_rvalid", 32'(bus.if_rvalid_o), 32'h1);
    chk("post_if_rdata",  bus.if_rdata_o,       32'h3401_1100);

    next_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 32, meaning the ROM address width.
REQ-002 The module SHALL have parameter DATA_W, default 32, meaning the ROM data width.
REQ-003 The module SHALL have parameter STARVE_LIMIT, default 8, meaning the number of consecutive refused debug cycles before the debug port is forced to win.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-006 The module SHALL have ports if_req_i (in, 1) and if_addr_i (in, ADDR_W): the fetch request and its address.
REQ-007 The module SHALL have ports if_gnt_o (out, 1), if_stall_o (out, 1), if_rvalid_o (out, 1) and if_rdata_o (out, DATA_W): fetch grant, stall, read-valid and read data.
REQ-008 The module SHALL have ports dbg_req_i (in, 1) and dbg_addr_i (in, ADDR_W): the debug/loader request and its address.
REQ-009 The module SHALL have ports dbg_gnt_o (out, 1), dbg_rvalid_o (out, 1) and dbg_rdata_o (out, DATA_W): debug grant, read-valid and read data.
REQ-010 The module SHALL have ports rom_ce_o (out, 1), rom_addr_o (out, ADDR_W) and rom_data_i (in, DATA_W) on the side of the combinational instruction ROM.
REQ-011 The module SHALL have port busy_o, output, 1 bit: high while a read response is pending.

Function
REQ-012 The module SHALL grant at most one port per cycle; grants SHALL be combinational from the current requests and the registered state.
REQ-013 By default, when both ports request, fetch SHALL win.
REQ-014 A lone requester SHALL always be granted in the same cycle.
REQ-015 rom_ce_o SHALL equal if_gnt_o OR dbg_gnt_o.
REQ-016 rom_addr_o SHALL carry the granted port's address, and SHALL be all-zero when there is no grant.
REQ-017 if_stall_o SHALL equal if_req_i AND NOT if_gnt_o.
REQ-018 rom_data_i SHALL be registered at the end of the grant cycle into the granted port's rdata register.
REQ-019 rvalid of the granted port SHALL pulse high for exactly one cycle in cycle N+1, giving fixed latency 1.
REQ-020 Each port's rdata SHALL hold its last value until that port's next rvalid.
REQ-021 A resp_owner register SHALL have states NONE, IF and DBG, and SHALL load the granted port, or NONE when there is no grant, every cycle.
REQ-022 rvalid routing SHALL be decoded from resp_owner; busy_o SHALL be high when resp_owner is not NONE.
REQ-023 Back-to-back grants SHALL be supported with no bubble, giving one read per cycle of throughput.
REQ-024 An address change on a requesting port while it is not granted SHALL be legal; the address sampled in the grant cycle is the one served.
REQ-025 A request dropped before it is granted SHALL produce no rvalid.

Reset
REQ-026 While rst is low, the module SHALL asynchronously clear resp_owner to NONE, all rvalid to 0, all rdata to 0 and the starvation counter to 0.
REQ-027 Combinational outputs SHALL follow their equations during reset; the pending-response state SHALL be cleared.
REQ-028 A response pending when reset asserts SHALL be discarded and SHALL never be delivered after reset is released.
REQ-029 The first grant SHALL be possible in the first cycle after rst goes high.

Configuration
REQ-030 Macro ROM_ARB_STARVE_GUARD_EN SHALL select the starvation guard.
REQ-031 When ROM_ARB_STARVE_GUARD_EN is defined, a starvation counter SHALL increment each cycle in which dbg_req_i=1 and dbg_gnt_o=0, saturating at STARVE_LIMIT.
REQ-032 When ROM_ARB_STARVE_GUARD_EN is defined and the counter equals STARVE_LIMIT, debug SHALL win that cycle even if fetch requests.
REQ-033 When ROM_ARB_STARVE_GUARD_EN is defined, the counter SHALL clear on a debug grant or when dbg_req_i=0.
REQ-034 When ROM_ARB_STARVE_GUARD_EN is undefined, there SHALL be no counter, fixed fetch priority SHALL apply, and debug may starve indefinitely.

Verification
REQ-035 Bench SHALL drive reset then a lone fetch at addr 0x0000_0004 with the ROM returning 0x3401_1100 -> if_gnt_o=1 and rom_addr_o=0x4 in cycle N, then if_rvalid_o=1 and if_rdata_o=0x3401_1100 in N+1 only.
REQ-036 Bench SHALL drive fetch 0x8 and debug 0x40 requesting together for one cycle -> fetch granted, if_stall_o=0, dbg_gnt_o=0, no dbg_rvalid_o.
REQ-037 Bench SHALL drive fetch addresses 0x0, 0x4, 0x8 on consecutive cycles -> three consecutive if_rvalid_o pulses with matching data and busy_o high for 3 cycles.
REQ-038 With the macro defined and STARVE_LIMIT=8, bench SHALL hold if_req_i and dbg_req_i high continuously -> debug granted exactly on cycle 9 with if_stall_o=1 that cycle, fetch granted otherwise, and the pattern repeating every 9 cycles.
REQ-039 With the macro undefined, bench SHALL repeat the scenario of REQ-038 for 50 cycles -> dbg_gnt_o never asserts.
REQ-040 Bench SHALL assert rst low in the cycle after a debug grant -> dbg_rvalid_o stays 0, dbg_rdata_o=0, busy_o=0, and the next request after release is served normally.
